// File: rtl/gonso_motor_seq.sv
// gonso_motor_seq: Wishbone-configured stepper-motor sequencer.
// Generates coil phases for io_out[35:32], counts steps, raises DONE irq.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i      Wishbone classic strobe, cycle, write
//   wbs_sel_i[3:0]            byte enables
//   wbs_adr_i[31:0]           byte address (window matched on [31:5])
//   wbs_dat_i[31:0]           write data
//   wbs_ack_o                 single-cycle acknowledge
//   wbs_dat_o[31:0]           read data, 0 when not acking
//   motor_o[3:0]              coil drive
//   busy_o                    move in progress
//   irq_o                     level interrupt (DONE & IRQ_EN)

module gonso_motor_seq #(
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0100,
    parameter logic [15:0] PERIOD_RST = 16'd999
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  motor_o,
    output logic        busy_o,
    output logic        irq_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PERIOD = 3'd1;
    localparam logic [2:0] OFF_STEPS  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;

    // Registers
    state_t      r_state;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_dir;
    logic        r_half;
    logic        r_irq_en;
    logic        r_hold;
    logic [15:0] r_period;
    logic [15:0] r_steps;
    logic [15:0] r_remaining;
    logic [15:0] r_cnt;
    logic [2:0]  r_phase;
    logic        r_done;
    logic [3:0]  r_motor;

    // Wires
    state_t      w_state_nxt;
    logic        w_match;
    logic        w_req;
    logic        w_wr;
    logic [2:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_period;
    logic        w_wr_steps;
    logic        w_start;
    logic        w_stop;
    logic        w_clr_done;
    logic        w_load;
    logic        w_step;
    logic        w_finish;
    logic [2:0]  w_delta;
    logic [2:0]  w_phase_step;
    logic [2:0]  w_phase_nxt;
    logic        w_hold_nxt;
    logic [3:0]  w_motor_nxt;
    logic [31:0] w_rdata;
    logic        w_unused;

    function automatic logic [3:0] coil(input logic [2:0] ph);
        logic [3:0] c;
        case (ph)
            3'd0:    c = 4'b1000;
            3'd1:    c = 4'b1100;
            3'd2:    c = 4'b0100;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0010;
            3'd5:    c = 4'b0011;
            3'd6:    c = 4'b0001;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] be16(
        input logic [15:0] old_v,
        input logic [15:0] new_v,
        input logic [1:0]  sel
    );
        return {sel[1] ? new_v[15:8] : old_v[15:8],
                sel[0] ? new_v[7:0]  : old_v[7:0]};
    endfunction

    // Bus decode. The ~r_ack term keeps ack low for the cycle after an ack.
    assign w_match = (wbs_adr_i[31:5] == ADDR_BASE[31:5]);
    assign w_req   = wbs_stb_i & wbs_cyc_i & w_match & ~r_ack;
    assign w_wr    = w_req & wbs_we_i;
    assign w_off   = wbs_adr_i[4:2];

    assign w_wr_ctrl   = w_wr & (w_off == OFF_CTRL) & wbs_sel_i[0];
    assign w_wr_period = w_wr & (w_off == OFF_PERIOD);
    assign w_wr_steps  = w_wr & (w_off == OFF_STEPS);
    assign w_start     = w_wr_ctrl & wbs_dat_i[0];
    assign w_stop      = w_wr_ctrl & wbs_dat_i[3];
    assign w_clr_done  = w_wr & (w_off == OFF_STATUS)
                       & wbs_sel_i[0] & wbs_dat_i[1];

    assign w_unused = ^{wbs_adr_i[1:0], wbs_sel_i[3:2],
                        wbs_dat_i[31:16]};

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // STOP in the same write overrides START
                if (w_start && !w_stop && (r_steps != 16'd0)) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 16'd0) begin
                    w_step = 1'b1;
                    if (r_remaining == 16'd1) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Full-step moves two table entries, keeping phase parity.
    assign w_delta      = r_half ? 3'd1 : 3'd2;
    assign w_phase_step = r_dir ? (r_phase + w_delta)
                                : (r_phase - w_delta);
    assign w_phase_nxt  = w_step ? w_phase_step : r_phase;
    assign w_hold_nxt   = w_wr_ctrl ? wbs_dat_i[5] : r_hold;

    // Coil output is registered from next-state values so it reflects
    // the phase and busy state right after the committing edge.
    always_comb begin
        w_motor_nxt = 4'b0000;
        if ((w_state_nxt == S_RUN) || w_hold_nxt) begin
            w_motor_nxt = coil(w_phase_nxt);
        end
    end

    // Read mux
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_CTRL: begin
                w_rdata = {26'd0, r_hold, r_irq_en, 1'b0,
                           r_half, r_dir, 1'b0};
            end
            OFF_PERIOD: w_rdata = {16'd0, r_period};
            OFF_STEPS:  w_rdata = {16'd0, r_steps};
            OFF_STATUS: begin
                w_rdata = {r_remaining, 11'd0, r_phase,
                           r_done, (r_state == S_RUN)};
            end
            default: w_rdata = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus and configuration registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_dir    <= 1'b0;
            r_half   <= 1'b0;
            r_irq_en <= 1'b0;
            r_hold   <= 1'b0;
            r_period <= PERIOD_RST;
            r_steps  <= 16'd0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs_we_i) ? w_rdata : 32'd0;
            if (w_wr_ctrl) begin
                r_dir    <= wbs_dat_i[1];
                r_half   <= wbs_dat_i[2];
                r_irq_en <= wbs_dat_i[4];
                r_hold   <= wbs_dat_i[5];
            end
            if (w_wr_period) begin
                r_period <= be16(r_period, wbs_dat_i[15:0],
                                 wbs_sel_i[1:0]);
            end
            if (w_wr_steps) begin
                r_steps <= be16(r_steps, wbs_dat_i[15:0],
                                wbs_sel_i[1:0]);
            end
        end
    end

    // Move datapath
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_remaining <= 16'd0;
            r_cnt       <= 16'd0;
            r_phase     <= 3'd0;
            r_done      <= 1'b0;
            r_motor     <= 4'b0000;
        end else begin
            if (w_load) begin
                r_remaining <= r_steps;
                r_cnt       <= r_period;
            end else if ((r_state == S_RUN) && !w_stop) begin
                if (w_step) begin
                    r_remaining <= r_remaining - 16'd1;
                    r_cnt       <= r_period;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
            end
            r_phase <= w_phase_nxt;
            if (w_load) begin
                r_done <= 1'b0;
            end else if (w_finish) begin
                r_done <= 1'b1;
            end else if (w_clr_done) begin
                r_done <= 1'b0;
            end
            r_motor <= w_motor_nxt;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign motor_o   = r_motor;
    assign busy_o    = (r_state == S_RUN);
    assign irq_o     = r_done & r_irq_en;

endmodule

// File: tb/tb_gonso_motor_seq.sv
// tb_gonso_motor_seq: register table vectors, directed moves and
// randomized moves checked against a step-time arithmetic model.
module tb_gonso_motor_seq;

    localparam logic [31:0] BASE = 32'h3000_0100;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic [31:0] dat_o;
    logic [3:0]  motor;
    logic        busy;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    int m_phase = 0;

    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    typedef struct {
        logic [31:0] off;
        bit          wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    gonso_motor_seq dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .motor_o   (motor),
        .busy_o    (busy),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_acc(input logic [31:0] a, input bit w,
                          input logic [31:0] d, input logic [3:0] s,
                          output bit acked, output logic [31:0] rd);
        adr = a;
        we = w;
        dat = d;
        sel = s;
        stb = 1'b1;
        cyc = 1'b1;
        acked = 1'b0;
        rd = 32'd0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk);
            #1;
            rd = dat_o;
            if (ack) acked = 1'b1;
        end
        stb = 1'b0;
        cyc = 1'b0;
        we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] off, input logic [31:0] d);
        bit a;
        logic [31:0] r;
        wb_acc(BASE + off, 1'b1, d, 4'hF, a, r);
        chk("wr_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic wb_rd(input logic [31:0] off, output logic [31:0] r);
        bit a;
        wb_acc(BASE + off, 1'b0, 32'd0, 4'hF, a, r);
        chk("rd_ack", {31'd0, a}, 32'd1);
    endtask

    // Model: step k lands at edge E + k*(per+1); phase moves by +-1
    // (half) or +-2 (full) per step, mod 8.
    task automatic run_move(input int per, input int st,
                            input logic [7:0] ctrl);
        int sgn;
        int sz;
        int sd;
        int ph;
        bit bz;
        logic [3:0] mt;
        logic [31:0] r;
        sgn = ctrl[1] ? 1 : -1;
        sz = ctrl[2] ? 1 : 2;
        ph = m_phase;
        wb_wr(32'h04, per);
        wb_wr(32'h08, st);
        wb_wr(32'h00, {24'd0, ctrl | 8'h01});
        for (int t = 0; t <= st * (per + 1) + 1; t++) begin
            sd = t / (per + 1);
            if (sd > st) sd = st;
            ph = (((m_phase + sgn * sz * sd) % 8) + 8) % 8;
            bz = (sd < st);
            mt = (bz || ctrl[5]) ? tbl[ph] : 4'b0000;
            chk($sformatf("move_t%0d", t),
                {26'd0, busy, irq, motor},
                {26'd0, bz, (!bz) & ctrl[4], mt});
            @(posedge clk);
            #1;
        end
        m_phase = ph;
        wb_rd(32'h0C, r);
        chk("move_status", r, {16'd0, 11'd0, ph[2:0], 1'b1, 1'b0});
        chk("move_irq", {31'd0, irq}, {31'd0, ctrl[4]});
        wb_wr(32'h0C, 32'h2);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
    endtask

    initial begin
        bit a;
        logic [31:0] r;
        logic [7:0] c;
        rst = 1'b1;
        stb = 1'b0;
        cyc = 1'b0;
        we = 1'b0;
        sel = 4'h0;
        adr = 32'd0;
        dat = 32'd0;
        cyc_wait(3);
        rst = 1'b0;
        chk("rst_outs", {22'd0, ack, busy, irq, motor, 3'd0},
            32'd0);
        chk("rst_dat", dat_o, 32'd0);

        // Register access vectors
        vecs.push_back('{32'h04, 0, 4'hF, 32'h0, 1, 32'h0000_03E7});
        vecs.push_back('{32'h0C, 0, 4'hF, 32'h0, 1, 32'h0});
        vecs.push_back('{32'h00, 0, 4'hF, 32'h0, 1, 32'h0});
        vecs.push_back('{32'h14, 0, 4'hF, 32'h0, 1, 32'h0});
        vecs.push_back('{32'h20, 0, 4'hF, 32'h0, 0, 32'h0});
        vecs.push_back('{32'h20, 1, 4'hF, 32'hFFFF, 0, 32'h0});
        vecs.push_back('{32'h04, 1, 4'h1, 32'hFFFF, 1, 32'h0});
        vecs.push_back('{32'h04, 0, 4'hF, 32'h0, 1, 32'h0000_03FF});
        vecs.push_back('{32'h08, 1, 4'h3, 32'h1234, 1, 32'h0});
        vecs.push_back('{32'h08, 1, 4'h2, 32'hAB00, 1, 32'h0});
        vecs.push_back('{32'h08, 0, 4'hF, 32'h0, 1, 32'h0000_AB34});
        vecs.push_back('{32'h00, 1, 4'h1, 32'h36, 1, 32'h0});
        vecs.push_back('{32'h00, 0, 4'hF, 32'h0, 1, 32'h36});
        vecs.push_back('{32'h00, 1, 4'h0, 32'h00, 1, 32'h0});
        vecs.push_back('{32'h00, 0, 4'hF, 32'h0, 1, 32'h36});
        vecs.push_back('{32'h00, 1, 4'h1, 32'h00, 1, 32'h0});
        vecs.push_back('{32'h00, 0, 4'hF, 32'h0, 1, 32'h0});
        vecs.push_back('{32'h14, 1, 4'hF, 32'hFFFF_FFFF, 1, 32'h0});
        vecs.push_back('{32'h14, 0, 4'hF, 32'h0, 1, 32'h0});
        vecs.push_back('{32'h0C, 1, 4'hF, 32'hFFFF_FFFF, 1, 32'h0});
        vecs.push_back('{32'h0C, 0, 4'hF, 32'h0, 1, 32'h0});
        foreach (vecs[i]) begin
            wb_acc(BASE + vecs[i].off, vecs[i].wr, vecs[i].wdata,
                   vecs[i].be, a, r);
            chk($sformatf("vec%0d_ack", i), {31'd0, a},
                {31'd0, vecs[i].exp_ack});
            if (!vecs[i].wr)
                chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
        end

        // Full-step forward move with interrupt
        run_move(3, 4, 8'h12);
        // Half-step reverse move, one step per cycle
        run_move(0, 3, 8'h04);

        // STOP mid-move
        wb_wr(32'h04, 9);
        wb_wr(32'h08, 100);
        wb_wr(32'h00, 32'h03);
        cyc_wait(25);
        wb_wr(32'h00, 32'h08);
        m_phase = (m_phase + 2 * 2) % 8;
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_motor", {28'd0, motor}, 32'd0);
        wb_rd(32'h0C, r);
        chk("stop_status", r,
            {16'd98, 11'd0, m_phase[2:0], 1'b0, 1'b0});
        wb_wr(32'h00, 32'h20);
        chk("hold_motor", {28'd0, motor}, {28'd0, tbl[m_phase]});
        wb_wr(32'h00, 32'h00);
        chk("unhold_motor", {28'd0, motor}, 32'd0);

        // START with STEPS=0, START+STOP together
        wb_wr(32'h08, 0);
        wb_wr(32'h00, 32'h01);
        cyc_wait(2);
        chk("start_zero", {31'd0, busy}, 32'd0);
        wb_wr(32'h08, 5);
        wb_wr(32'h00, 32'h09);
        cyc_wait(2);
        chk("start_stop", {31'd0, busy}, 32'd0);

        // START during RUN leaves the move alone
        wb_wr(32'h00, 32'h03);
        chk("run_busy", {31'd0, busy}, 32'd1);
        wb_wr(32'h08, 50);
        wb_wr(32'h00, 32'h03);
        wb_rd(32'h0C, r);
        chk("restart_status", r,
            {16'd5, 11'd0, m_phase[2:0], 1'b0, 1'b1});
        wb_wr(32'h00, 32'h08);
        chk("restart_stop", {31'd0, busy}, 32'd0);

        // Randomized moves
        for (int k = 0; k < 8; k++) begin
            c = {2'b00, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'b1};
            run_move($urandom_range(4), $urandom_range(6, 1), c);
        end

        // Reset in the middle of a move
        wb_wr(32'h04, 2);
        wb_wr(32'h08, 10);
        wb_wr(32'h00, 32'h33);
        cyc_wait(5);
        rst = 1'b1;
        cyc_wait(1);
        chk("mid_rst", {26'd0, ack, busy, irq, motor},
            32'd0);
        rst = 1'b0;
        m_phase = 0;
        wb_rd(32'h04, r);
        chk("mid_rst_period", r, 32'h0000_03E7);
        wb_rd(32'h0C, r);
        chk("mid_rst_status", r, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
